// File: rtl/udp_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : udp_pattern_gen
//  Brief    : Windowed burst traffic source for the UDP user write port,
//             with four data patterns, ready backpressure and debug counters.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_pattern_gen #(
    parameter int DATA_W        = 32,
    parameter int WINDOW_CYCLES = 125_000_000,
    parameter int SAMPLE_DIV    = 47,
    parameter int BURST_LEN     = 10,
    parameter int CNT_W         = 16
) (
    input  logic              i_Sys_clk,
    input  logic              i_Rst_n,
    input  logic              i_Enable,
    input  logic [1:0]        i_Mode,
    input  logic [DATA_W-1:0] i_Const,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Valid,
    output logic              o_Last,
    input  logic              i_Ready,
    output logic              o_Busy,
    output logic [CNT_W-1:0]  o_Frame_cnt,
    output logic [CNT_W-1:0]  o_Drop_cnt,
    output logic [CNT_W-1:0]  o_Miss_cnt
);

    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int SMP_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [WIN_W-1:0]  c_WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SMP_W-1:0]  c_SMP_LAST  = SMP_W'(SAMPLE_DIV - 1);
    // The window-start cycle itself counts as sample phase 0.
    localparam logic [SMP_W-1:0]  c_SMP_FIRST = SMP_W'((SAMPLE_DIV > 1) ? 1 : 0);
    localparam logic [BEAT_W-1:0] c_BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [31:0]       c_LFSR_SEED = 32'h0000_0001;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [SMP_W-1:0]  r_smp_cnt, w_smp_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt, w_beat_eff;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [DATA_W-1:0] r_free, w_free_nxt, w_free_eff;
    logic [31:0]       r_lfsr, w_lfsr_nxt, w_lfsr_eff;
    logic [DATA_W-1:0] r_data, w_data_nxt, w_pattern;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic [CNT_W-1:0]  r_frame, w_frame_nxt;
    logic [CNT_W-1:0]  r_drop, w_drop_nxt;
    logic [CNT_W-1:0]  r_miss, w_miss_nxt;
    logic              w_ws, w_accept, w_tick;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    always_ff @(posedge i_Sys_clk) begin
        if (!i_Rst_n)
            r_win_cnt <= '0;
        else if (r_win_cnt == c_WIN_LAST)
            r_win_cnt <= '0;
        else
            r_win_cnt <= r_win_cnt + 1'b1;
    end

    assign w_ws     = (r_win_cnt == '0);
    assign w_accept = r_valid & i_Ready;
    assign w_tick   = (r_state != c_ST_IDLE) && (r_smp_cnt == c_SMP_LAST);

    // Pattern state as seen after any acceptance in this cycle, so a beat
    // loaded on the same clock as an acceptance carries the next value.
    assign w_beat_eff = w_accept ? r_beat + 1'b1 : r_beat;
    assign w_free_eff = w_accept ? r_free + 1'b1 : r_free;
    assign w_lfsr_eff = w_accept ? lfsr_step(r_lfsr) : r_lfsr;

    always_comb begin
        w_pattern = '0;
        case (r_mode)
            2'd0:    w_pattern = DATA_W'(w_beat_eff);
            2'd1:    w_pattern = w_free_eff;
            2'd2:    w_pattern = DATA_W'(w_lfsr_eff);
            default: w_pattern = i_Const;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_smp_nxt   = r_smp_cnt;
        w_beat_nxt  = w_beat_eff;
        w_mode_nxt  = r_mode;
        w_free_nxt  = w_free_eff;
        w_lfsr_nxt  = w_lfsr_eff;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_frame_nxt = r_frame;
        w_drop_nxt  = r_drop;
        w_miss_nxt  = r_miss;

        if (r_state != c_ST_IDLE)
            w_smp_nxt = (r_smp_cnt == c_SMP_LAST) ? '0 : r_smp_cnt + 1'b1;

        if (w_ws && (r_state != c_ST_IDLE) && (r_miss != c_CNT_MAX))
            w_miss_nxt = r_miss + 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                w_smp_nxt = '0;
                if (w_ws && i_Enable) begin
                    w_state_nxt = c_ST_RUN;
                    w_mode_nxt  = i_Mode;
                    w_beat_nxt  = '0;
                    w_smp_nxt   = c_SMP_FIRST;
                end
            end
            c_ST_RUN: begin
                if (w_tick) begin
                    w_state_nxt = c_ST_HOLD;
                    w_data_nxt  = w_pattern;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (w_beat_eff == c_BEAT_LAST);
                end
            end
            c_ST_HOLD: begin
                if (w_accept) begin
                    if (r_last) begin
                        w_state_nxt = c_ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_beat_nxt  = '0;
                        w_smp_nxt   = '0;
                        w_frame_nxt = r_frame + 1'b1;
                    end else if (w_tick) begin
                        w_data_nxt  = w_pattern;
                        w_last_nxt  = (w_beat_eff == c_BEAT_LAST);
                    end else begin
                        w_state_nxt = c_ST_RUN;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end else if (w_tick && (r_drop != c_CNT_MAX)) begin
                    w_drop_nxt = r_drop + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Sys_clk) begin
        if (!i_Rst_n) begin
            r_state   <= c_ST_IDLE;
            r_smp_cnt <= '0;
            r_beat    <= '0;
            r_mode    <= '0;
            r_free    <= '0;
            r_lfsr    <= c_LFSR_SEED;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_frame   <= '0;
            r_drop    <= '0;
            r_miss    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_smp_cnt <= w_smp_nxt;
            r_beat    <= w_beat_nxt;
            r_mode    <= w_mode_nxt;
            r_free    <= w_free_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_last    <= w_last_nxt;
            r_frame   <= w_frame_nxt;
            r_drop    <= w_drop_nxt;
            r_miss    <= w_miss_nxt;
        end
    end

    assign o_Data      = r_data;
    assign o_Valid     = r_valid;
    assign o_Last      = r_last;
    assign o_Busy      = (r_state != c_ST_IDLE);
    assign o_Frame_cnt = r_frame;
    assign o_Drop_cnt  = r_drop;
    assign o_Miss_cnt  = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_udp_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_pattern_gen
//  Brief    : Directed self-checking bench for udp_pattern_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udp_pattern_gen;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [DATA_W-1:0] cnst = '0;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] data;
    logic              valid, last, busy;
    logic [CNT_W-1:0]  frame_cnt, drop_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [31:0] m_lfsr;

    always #5 clk = ~clk;

    udp_pattern_gen #(
        .DATA_W(DATA_W), .WINDOW_CYCLES(200), .SAMPLE_DIV(4),
        .BURST_LEN(5), .CNT_W(CNT_W)
    ) dut (
        .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Mode(mode),
        .i_Const(cnst), .o_Data(data), .o_Valid(valid), .o_Last(last),
        .i_Ready(ready), .o_Busy(busy), .o_Frame_cnt(frame_cnt),
        .o_Drop_cnt(drop_cnt), .o_Miss_cnt(miss_cnt)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench at the first window-start cycle (cycle 0).
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        pl = 1'b0;
        q_data.delete();
        q_last.delete();
    endtask

    // Run until cycle 'upto' with ready low on cycles rlo..rhi; records every
    // accepted beat and checks that a stalled beat stays stable.
    task automatic run(input int upto, input int rlo, input int rhi);
        while (cyc < upto) begin
            step();
            ready = !(cyc >= rlo && cyc <= rhi);
            if (pv && !pr) begin
                check("hold_valid", valid, 1);
                check("hold_data", data, pd);
                check("hold_last", last, pl);
            end
            if (valid && ready) begin
                q_data.push_back(data);
                q_last.push_back(last);
            end
            pv = valid;
            pr = ready;
            pd = data;
            pl = last;
        end
    endtask

    task automatic check_idx_beats(input string tag);
        check({tag, "_nbeats"}, q_data.size(), 5);
        for (int i = 0; i < q_data.size() && i < 5; i++) begin
            check({tag, "_data"}, q_data[i], i);
            check({tag, "_last"}, q_last[i], (i == 4));
        end
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        step();
        step();
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_miss", miss_cnt, 0);

        // Mode 0, always ready: beats at cycles 4,8,..,20 carry 0..4
        enable = 1'b1;
        mode = 2'd0;
        ready = 1'b1;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            step();
            check("m0_valid", valid, (c % 4 == 0) && (c >= 4) && (c <= 20));
            if (valid) begin
                check("m0_data", data, c / 4 - 1);
                check("m0_last", last, c == 20);
            end
            if (c == 1) check("m0_busy_on", busy, 1);
            if (c == 21) check("m0_busy_off", busy, 0);
        end
        check("m0_frame", frame_cnt, 1);
        check("m0_drop", drop_cnt, 0);

        // Mode 1 over three windows: counter continues across bursts
        mode = 2'd1;
        do_reset();
        run(425, -1, -1);
        check("m1_nbeats", q_data.size(), 15);
        for (int i = 0; i < q_data.size() && i < 15; i++) begin
            check("m1_data", q_data[i], i);
            check("m1_last", q_last[i], (i % 5) == 4);
        end
        check("m1_frame", frame_cnt, 3);
        check("m1_miss", miss_cnt, 0);

        // Mode 2: LFSR seeded with 1, stepped per accepted beat
        mode = 2'd2;
        do_reset();
        run(225, -1, -1);
        check("m2_nbeats", q_data.size(), 10);
        if (q_data.size() >= 2) begin
            check("m2_beat0", q_data[0], 32'h0000_0001);
            check("m2_beat1", q_data[1], 32'h0000_0003);
        end
        m_lfsr = 32'h0000_0001;
        for (int i = 0; i < q_data.size() && i < 10; i++) begin
            check("m2_model", q_data[i], m_lfsr);
            m_lfsr = lfsr_next(m_lfsr);
        end

        // Backpressure for 10 cycles from the first valid: two drops
        mode = 2'd0;
        do_reset();
        run(40, 4, 13);
        check_idx_beats("bp");
        check("bp_drop", drop_cnt, 2);
        check("bp_frame", frame_cnt, 1);

        // Long stall across a window start: one missed window
        do_reset();
        run(201, 0, 253);
        check("miss_cnt", miss_cnt, 1);
        check("miss_busy", busy, 1);
        run(300, 0, 253);
        enable = 1'b0;
        check_idx_beats("miss");
        check("miss_frame", frame_cnt, 1);
        check("miss_drop", drop_cnt, 62);

        // Mode 3 with mode change mid-burst: constant sampled at beat load
        enable = 1'b1;
        mode = 2'd3;
        cnst = 32'hCAFE_0001;
        do_reset();
        run(2, -1, -1);
        mode = 2'd0;
        enable = 1'b0;
        run(30, -1, -1);
        check("m3_nbeats", q_data.size(), 5);
        for (int i = 0; i < q_data.size() && i < 5; i++)
            check("m3_data", q_data[i], 32'hCAFE_0001);
        check("m3_frame", frame_cnt, 1);

        // Reset while a beat is valid
        enable = 1'b1;
        mode = 2'd0;
        do_reset();
        run(8, 4, 8);
        check("mr_pre_valid", valid, 1);
        check("mr_pre_drop", drop_cnt, 1);
        rst_n = 1'b0;
        step();
        check("mr_valid", valid, 0);
        check("mr_last", last, 0);
        check("mr_busy", busy, 0);
        check("mr_data", data, 0);
        check("mr_drop", drop_cnt, 0);
        check("mr_frame", frame_cnt, 0);
        rst_n = 1'b1;
        cyc = 0;
        pv = 1'b0;
        pr = 1'b1;
        q_data.delete();
        q_last.delete();
        run(24, -1, -1);
        check_idx_beats("mr");
        check("mr_post_frame", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
